mem_port_arbiter: RTL and testbench

- Shares the single 128-bit line-wide main-memory port between the instruction cache (refill reads only) and the data cache (refill reads and dirty-line writebacks).
- Sits between the fetch-stage I-cache and memory-stage D-cache on one side and the memory model/controller on the other.
- Serves one transaction at a time, with round-robin priority, registered response return and a watchdog timeout.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_port_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the main-memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 26;
  localparam int unsigned LINE_W_DEF = 128;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP,
    RELEASE
  } arb_state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between I-cache refills
// and D-cache refills/writebacks, one transaction at a time, with a watchdog.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned LINE_W      = LINE_W_DEF,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reqI_mem,
  input  logic [ADDR_W-1:0] reqAddrI_mem,
  output logic [LINE_W-1:0] instr_to_icache,
  output logic              read_ready_I,
  input  logic              reqD_mem,
  input  logic              reqD_we,
  input  logic [ADDR_W-1:0] reqAddrD_mem,
  input  logic [LINE_W-1:0] reqD_wdata,
  output logic [LINE_W-1:0] data_to_dcache,
  output logic              read_ready_D,
  output logic              written_ack_D,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_read_ready,
  input  logic              mem_write_ack,
  output logic              mem_err
);

  localparam int unsigned WD_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

  arb_state_t        state, state_nx;
  owner_t            owner, owner_nx;
  owner_t            prefer, prefer_nx;
  owner_t            grant;
  logic              dropped, dropped_nx;
  logic [WD_W-1:0]   wd_cnt, wd_cnt_nx;
  logic              owner_req, done, timeout, drop_now;

  logic              mem_req_nx, mem_we_nx, mem_err_nx;
  logic [ADDR_W-1:0] mem_addr_nx;
  logic [LINE_W-1:0] mem_wdata_nx, instr_nx, data_nx;
  logic              rdy_i_nx, rdy_d_nx, wack_nx;

  // Pointer breaks ties only when both caches are asking.
  function automatic owner_t pick(input logic req_i, input logic req_d, input owner_t pref);
    if (req_i && req_d) return pref;
    return req_d ? OWN_D : OWN_I;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= IDLE;
      owner           <= OWN_I;
      prefer          <= OWN_D;
      dropped         <= 1'b0;
      wd_cnt          <= '0;
      mem_req         <= 1'b0;
      mem_we          <= 1'b0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      mem_err         <= 1'b0;
      instr_to_icache <= '0;
      data_to_dcache  <= '0;
      read_ready_I    <= 1'b0;
      read_ready_D    <= 1'b0;
      written_ack_D   <= 1'b0;
    end else begin
      state           <= state_nx;
      owner           <= owner_nx;
      prefer          <= prefer_nx;
      dropped         <= dropped_nx;
      wd_cnt          <= wd_cnt_nx;
      mem_req         <= mem_req_nx;
      mem_we          <= mem_we_nx;
      mem_addr        <= mem_addr_nx;
      mem_wdata       <= mem_wdata_nx;
      mem_err         <= mem_err_nx;
      instr_to_icache <= instr_nx;
      data_to_dcache  <= data_nx;
      read_ready_I    <= rdy_i_nx;
      read_ready_D    <= rdy_d_nx;
      written_ack_D   <= wack_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    owner_nx     = owner;
    prefer_nx    = prefer;
    dropped_nx   = dropped;
    wd_cnt_nx    = wd_cnt;
    mem_req_nx   = mem_req;
    mem_we_nx    = mem_we;
    mem_addr_nx  = mem_addr;
    mem_wdata_nx = mem_wdata;
    mem_err_nx   = mem_err;
    instr_nx     = instr_to_icache;
    data_nx      = data_to_dcache;
    rdy_i_nx     = 1'b0;
    rdy_d_nx     = 1'b0;
    wack_nx      = 1'b0;

    grant     = pick(reqI_mem, reqD_mem, prefer);
    owner_req = (owner == OWN_D) ? reqD_mem : reqI_mem;
    done      = mem_we ? mem_write_ack : mem_read_ready;
    timeout   = (TIMEOUT_CYC != 0) && (32'(wd_cnt) == TIMEOUT_CYC - 32'd1);
    drop_now  = dropped || !owner_req;

    case (state)
      IDLE: begin
        if (reqI_mem || reqD_mem) begin
          owner_nx     = grant;
          mem_we_nx    = (grant == OWN_D) && reqD_we;
          mem_addr_nx  = (grant == OWN_D) ? reqAddrD_mem : reqAddrI_mem;
          mem_wdata_nx = (grant == OWN_D) ? reqD_wdata : '0;
          if (reqI_mem && reqD_mem) prefer_nx = (grant == OWN_D) ? OWN_I : OWN_D;
          mem_req_nx   = 1'b1;
          wd_cnt_nx    = '0;
          dropped_nx   = 1'b0;
          state_nx     = BUSY;
        end
      end
      BUSY: begin
        wd_cnt_nx  = wd_cnt + WD_W'(1);
        dropped_nx = drop_now;
        if (done) begin
          mem_req_nx = 1'b0;
          state_nx   = RESP;
          // A requester that let go mid-transaction gets no pulse and no line update.
          if (!drop_now) begin
            if (mem_we) begin
              wack_nx = 1'b1;
            end else if (owner == OWN_D) begin
              rdy_d_nx = 1'b1;
              data_nx  = mem_rdata;
            end else begin
              rdy_i_nx = 1'b1;
              instr_nx = mem_rdata;
            end
          end
        end else if (timeout) begin
          mem_req_nx = 1'b0;
          mem_err_nx = 1'b1;
          state_nx   = RELEASE;
        end
      end
      RESP:    state_nx = RELEASE;
      RELEASE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table of single transactions plus
// hand sequences for contention, flush, watchdog timeout and mid-busy reset.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 26;
  localparam int unsigned LW = 128;

  logic          clk = 1'b0;
  logic          reset;
  logic          reqI_mem, reqD_mem, reqD_we;
  logic [AW-1:0] reqAddrI_mem, reqAddrD_mem, mem_addr;
  logic [LW-1:0] reqD_wdata, instr_to_icache, data_to_dcache, mem_wdata, mem_rdata;
  logic          read_ready_I, read_ready_D, written_ack_D;
  logic          mem_req, mem_we, mem_read_ready, mem_write_ack, mem_err;

  mem_port_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .reset(reset),
    .reqI_mem(reqI_mem), .reqAddrI_mem(reqAddrI_mem),
    .instr_to_icache(instr_to_icache), .read_ready_I(read_ready_I),
    .reqD_mem(reqD_mem), .reqD_we(reqD_we), .reqAddrD_mem(reqAddrD_mem),
    .reqD_wdata(reqD_wdata), .data_to_dcache(data_to_dcache),
    .read_ready_D(read_ready_D), .written_ack_D(written_ack_D),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_read_ready(mem_read_ready),
    .mem_write_ack(mem_write_ack), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          req_i, req_d, we, wrong;
    logic [AW-1:0] addr_i, addr_d;
    logic [LW-1:0] wdata, rdata;
    int            lat;
    logic [AW-1:0] exp_addr;
    logic          exp_we;
    logic [2:0]    exp_pulse;   // {read_ready_I, read_ready_D, written_ack_D}
  } vec_t;

  int unsigned   n_cmp = 0;
  int unsigned   n_bad = 0;
  logic [LW-1:0] exp_instr = '0;
  logic [LW-1:0] exp_data  = '0;
  vec_t          tbl [6];

  function automatic vec_t mk(input logic ri, input logic rd, input logic we, input logic wrong,
                              input logic [AW-1:0] ai, input logic [AW-1:0] ad,
                              input logic [LW-1:0] wd, input logic [LW-1:0] rdat, input int lat,
                              input logic [AW-1:0] ea, input logic ew, input logic [2:0] ep);
    vec_t v;
    v.req_i = ri; v.req_d = rd; v.we = we; v.wrong = wrong;
    v.addr_i = ai; v.addr_d = ad; v.wdata = wd; v.rdata = rdat; v.lat = lat;
    v.exp_addr = ea; v.exp_we = ew; v.exp_pulse = ep;
    return v;
  endfunction

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_instr"}, instr_to_icache, '0);
    chk({tag, "_data"}, data_to_dcache, '0);
    chk({tag, "_ctrl"}, LW'({read_ready_I, read_ready_D, written_ack_D, mem_req, mem_we, mem_err}), '0);
    chk({tag, "_addr"}, LW'(mem_addr), '0);
    chk({tag, "_wdata"}, mem_wdata, '0);
  endtask

  // One complete transaction starting and ending at a negedge with the DUT in IDLE.
  task automatic run_txn(input vec_t v, input string tag);
    reqI_mem = v.req_i; reqD_mem = v.req_d; reqD_we = v.we;
    reqAddrI_mem = v.addr_i; reqAddrD_mem = v.addr_d; reqD_wdata = v.wdata;
    @(negedge clk);
    chk({tag, "_req"}, LW'(mem_req), LW'(1'b1));
    chk({tag, "_addr"}, LW'(mem_addr), LW'(v.exp_addr));
    chk({tag, "_we"}, LW'(mem_we), LW'(v.exp_we));
    if (v.exp_we) chk({tag, "_wdata"}, mem_wdata, v.wdata);
    for (int k = 0; k < v.lat; k++) begin
      if (k == 0 && v.wrong) begin
        mem_rdata = ~v.rdata;
        if (v.exp_we) mem_read_ready = 1'b1;
        else          mem_write_ack  = 1'b1;
      end
      @(negedge clk);
      mem_read_ready = 1'b0; mem_write_ack = 1'b0;
      chk({tag, "_hold"}, LW'(mem_req), LW'(1'b1));
    end
    mem_rdata = v.rdata;
    if (v.exp_we) mem_write_ack = 1'b1;
    else          mem_read_ready = 1'b1;
    @(negedge clk);
    mem_read_ready = 1'b0; mem_write_ack = 1'b0;
    if (v.exp_pulse[2]) exp_instr = v.rdata;
    if (v.exp_pulse[1]) exp_data  = v.rdata;
    chk({tag, "_pulse"}, LW'({read_ready_I, read_ready_D, written_ack_D}), LW'(v.exp_pulse));
    chk({tag, "_instr"}, instr_to_icache, exp_instr);
    chk({tag, "_data"}, data_to_dcache, exp_data);
    chk({tag, "_reqdrop"}, LW'(mem_req), '0);
    reqI_mem = 1'b0; reqD_mem = 1'b0;
    @(negedge clk);
    chk({tag, "_rel"}, LW'({read_ready_I, read_ready_D, written_ack_D, mem_req}), '0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    reqI_mem = 1'b0; reqD_mem = 1'b0; reqD_we = 1'b0;
    reqAddrI_mem = '0; reqAddrD_mem = '0; reqD_wdata = '0;
    mem_rdata = '0; mem_read_ready = 1'b0; mem_write_ack = 1'b0;

    tbl[0] = mk(1, 0, 0, 0, 26'h10, 26'h0, '0, 128'hA1A1_0000_1111_2222_3333_4444_5555_6666, 3,
                26'h10, 0, 3'b100);
    tbl[1] = mk(0, 1, 1, 0, 26'h0, 26'h2A, 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF, '0, 2,
                26'h2A, 1, 3'b001);
    tbl[2] = mk(0, 1, 0, 0, 26'h0, 26'h3FF_FFFF, '0, 128'hB2B2_7777_8888_9999_AAAA_BBBB_CCCC_DDDD, 0,
                26'h3FF_FFFF, 0, 3'b010);
    tbl[3] = mk(1, 1, 0, 0, 26'h111, 26'h222, '0, 128'hC3C3_0123_4567_89AB_CDEF_0123_4567_89AB, 1,
                26'h222, 0, 3'b010);
    tbl[4] = mk(1, 1, 0, 1, 26'h333, 26'h444, '0, 128'hD4D4_FEDC_BA98_7654_3210_FEDC_BA98_7654, 2,
                26'h333, 0, 3'b100);
    tbl[5] = mk(0, 1, 1, 1, 26'h0, 26'h0, {LW{1'b1}}, 128'h5, 2,
                26'h0, 1, 3'b001);

    repeat (2) @(negedge clk);
    chk_zero("reset");
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    // Contention from reset: both held, grants must alternate D, I, D, I.
    reqI_mem = 1'b1; reqD_mem = 1'b1; reqD_we = 1'b0;
    reqAddrI_mem = 26'h40; reqAddrD_mem = 26'h80;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    exp_instr = '0; exp_data = '0;
    for (int g = 0; g < 4; g++) begin
      logic is_d;
      is_d = (g % 2) == 0;
      @(negedge clk);
      chk($sformatf("rr%0d_addr", g), LW'(mem_addr), is_d ? LW'(26'h80) : LW'(26'h40));
      mem_rdata = LW'(g + 100);
      mem_read_ready = 1'b1;
      @(negedge clk);
      mem_read_ready = 1'b0;
      chk($sformatf("rr%0d_pulse", g), LW'({read_ready_I, read_ready_D, written_ack_D}),
          is_d ? LW'(3'b010) : LW'(3'b100));
      @(negedge clk);
      @(negedge clk);
    end
    reqI_mem = 1'b0; reqD_mem = 1'b0;
    exp_instr = LW'(103); exp_data = LW'(102);
    chk("rr_instr", instr_to_icache, exp_instr);
    chk("rr_data", data_to_dcache, exp_data);
    @(negedge clk);

    // Flush: I drops its request one cycle into BUSY.
    reqI_mem = 1'b1; reqAddrI_mem = 26'h55;
    @(negedge clk);
    chk("flush_req", LW'(mem_req), LW'(1'b1));
    reqI_mem = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("flush_hold", LW'(mem_req), LW'(1'b1));
    end
    mem_rdata = 128'hFFFF_EEEE; mem_read_ready = 1'b1;
    @(negedge clk);
    mem_read_ready = 1'b0;
    chk("flush_pulse", LW'(read_ready_I), '0);
    chk("flush_instr", instr_to_icache, exp_instr);
    chk("flush_reqdrop", LW'(mem_req), '0);
    repeat (2) @(negedge clk);

    // Watchdog: memory silent, mem_req must last exactly 8 BUSY cycles.
    reqD_mem = 1'b1; reqD_we = 1'b0; reqAddrD_mem = 26'h99;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("wd_hold%0d", k), LW'(mem_req), LW'(1'b1));
    end
    @(negedge clk);
    chk("wd_reqdrop", LW'(mem_req), '0);
    chk("wd_err", LW'(mem_err), LW'(1'b1));
    chk("wd_nopulse", LW'({read_ready_I, read_ready_D, written_ack_D}), '0);
    reqD_mem = 1'b0;
    @(negedge clk);
    chk("wd_err_sticky", LW'(mem_err), LW'(1'b1));
    run_txn(tbl[0], "post_wd");
    chk("wd_err_still", LW'(mem_err), LW'(1'b1));

    // Reset asserted for one cycle while BUSY.
    reqI_mem = 1'b1; reqAddrI_mem = 26'h77;
    @(negedge clk);
    chk("rb_req", LW'(mem_req), LW'(1'b1));
    reset = 1'b0; reqI_mem = 1'b0;
    @(negedge clk);
    chk_zero("rst_busy");
    reset = 1'b1;
    exp_instr = '0; exp_data = '0;
    @(negedge clk);
    run_txn(tbl[2], "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
